// File: rtl/bcp_dispatch_pkg.sv
// Shared definitions for the BCP clause dispatcher and its arbiter.
package bcp_dispatch_pkg;

  // Clause index width and the default number of parallel BCP cores.
  localparam int MAX_CLAUSES_BITS = 8;
  localparam int BCP_NUM_CORES    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/bcp_dispatch_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after the
// pointer, and moves the pointer one past the winner when told to advance.
module bcp_dispatch_rr_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NUM_CORES-1:0] i_req,
  input  logic                 i_advance,
  output logic [NUM_CORES-1:0] o_grant
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0]       r_ptr;
  logic [2*NUM_CORES-1:0] w_req_dbl;
  logic [2*NUM_CORES-1:0] w_req_shift;
  logic [NUM_CORES-1:0]   w_req_rot;
  logic [NUM_CORES-1:0]   w_sel;
  logic [2*NUM_CORES-1:0] w_grant_dbl;
  logic [PTR_W-1:0]       w_gidx;

  // Rotate requests so the pointer position lands on bit 0.
  assign w_req_dbl   = {i_req, i_req};
  assign w_req_shift = w_req_dbl >> r_ptr;
  assign w_req_rot   = w_req_shift[NUM_CORES-1:0];

  // Lowest set bit of the rotated request wins.
  always_comb begin
    w_sel = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_sel    = '0;
        w_sel[j] = 1'b1;
      end
    end
  end

  // Rotate the winner back into core numbering.
  assign w_grant_dbl = {{NUM_CORES{1'b0}}, w_sel} << r_ptr;
  assign o_grant     = w_grant_dbl[NUM_CORES-1:0] | w_grant_dbl[2*NUM_CORES-1:NUM_CORES];

  // Encode the granted core number for the pointer update.
  always_comb begin
    w_gidx = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (o_grant[j]) w_gidx = PTR_W'(j);
    end
  end

  // Pointer moves one past the granted core, only when a grant is used.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_advance && (|o_grant)) begin
      r_ptr <= (w_gidx == PTR_W'(NUM_CORES - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

endmodule

// File: rtl/bcp_dispatch.sv
// Dispatches one BCP pass over [start_clause, end_clause) to a bank of
// parallel BCP cores, one clause per cycle, and reports done/conflict once
// every issued clause has been evaluated.
//
// state | meaning
// IDLE  | waiting for start; conflict result of the last pass held
// ISSUE | handing clauses to idle cores round-robin
// DRAIN | no more issue; waiting for outstanding clauses to finish
// DONE  | done pulse cycle; start ignored here
module bcp_dispatch
  import bcp_dispatch_pkg::*;
#(
  parameter int NUM_CORES   = BCP_NUM_CORES,
  parameter int CLAUSE_BITS = MAX_CLAUSES_BITS
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [CLAUSE_BITS-1:0] i_start_clause,
  input  logic [CLAUSE_BITS-1:0] i_end_clause,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_conflict,
  output logic                   o_reset_bcp,
  output logic [NUM_CORES-1:0]   o_issue_valid,
  output logic [CLAUSE_BITS-1:0] o_issue_clause_idx,
  input  logic [NUM_CORES-1:0]   i_core_done,
  input  logic [NUM_CORES-1:0]   i_core_conflict
);

  dispatch_state_t        r_state;
  logic [CLAUSE_BITS-1:0] r_next_idx;
  logic [CLAUSE_BITS-1:0] r_end_idx;
  logic [NUM_CORES-1:0]   r_pending;
  logic                   r_conflict_seen;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_conflict;
  logic                   r_reset_bcp;
  logic [NUM_CORES-1:0]   r_issue_valid;
  logic [CLAUSE_BITS-1:0] r_issue_idx;

  logic [NUM_CORES-1:0]   w_grant;
  logic                   w_issue_now;
  logic                   w_hit_conflict;

  bcp_dispatch_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_req     (~r_pending),
    .i_advance (w_issue_now),
    .o_grant   (w_grant)
  );

  // A clause goes out only while issuing, no conflict yet, range left, a core free.
  assign w_issue_now = (r_state == ST_ISSUE) && !r_conflict_seen &&
                       (r_next_idx != r_end_idx) && (|w_grant);

  // Completions on cores with nothing outstanding are not counted.
  assign w_hit_conflict = |(i_core_done & i_core_conflict & r_pending);

  // Dispatch FSM, index counter, outstanding-clause tracking and result flags.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_next_idx      <= '0;
      r_end_idx       <= '0;
      r_pending       <= '0;
      r_conflict_seen <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_conflict      <= 1'b0;
      r_reset_bcp     <= 1'b0;
      r_issue_valid   <= '0;
      r_issue_idx     <= '0;
    end else begin
      r_done        <= 1'b0;
      r_reset_bcp   <= 1'b0;
      r_issue_valid <= '0;
      r_pending     <= (r_pending & ~i_core_done) | (w_issue_now ? w_grant : '0);

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_next_idx      <= i_start_clause;
            // A reversed range collapses to empty instead of wrapping.
            r_end_idx       <= (i_start_clause > i_end_clause) ? i_start_clause : i_end_clause;
            r_conflict      <= 1'b0;
            r_conflict_seen <= 1'b0;
            r_busy          <= 1'b1;
            r_reset_bcp     <= 1'b1;
            r_state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_conflict_seen <= r_conflict_seen | w_hit_conflict;
          if (r_conflict_seen || (r_next_idx == r_end_idx)) begin
            r_state <= ST_DRAIN;
          end else if (w_issue_now) begin
            r_issue_valid <= w_grant;
            r_issue_idx   <= r_next_idx;
            r_next_idx    <= r_next_idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_conflict_seen <= r_conflict_seen | w_hit_conflict;
          if ((r_pending == '0) && (i_core_done == '0)) begin
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_conflict <= r_conflict_seen;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_conflict         = r_conflict;
  assign o_reset_bcp        = r_reset_bcp;
  assign o_issue_valid      = r_issue_valid;
  assign o_issue_clause_idx = r_issue_idx;

endmodule

// File: tb/tb_bcp_dispatch.sv
// Bench for bcp_dispatch: a table of directed passes, a reset-abort
// sequence and randomized passes, all checked cycle by cycle against a
// pass-level model of cores, clause order and round-robin fairness.
module tb_bcp_dispatch;

  localparam int NC = 4;
  localparam int CB = 8;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [CB-1:0] i_start_clause;
  logic [CB-1:0] i_end_clause;
  logic          o_busy;
  logic          o_done;
  logic          o_conflict;
  logic          o_reset_bcp;
  logic [NC-1:0] o_issue_valid;
  logic [CB-1:0] o_issue_clause_idx;
  logic [NC-1:0] i_core_done;
  logic [NC-1:0] i_core_conflict;

  bcp_dispatch #(.NUM_CORES(NC), .CLAUSE_BITS(CB)) dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_start            (i_start),
    .i_start_clause     (i_start_clause),
    .i_end_clause       (i_end_clause),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_conflict         (o_conflict),
    .o_reset_bcp        (o_reset_bcp),
    .o_issue_valid      (o_issue_valid),
    .o_issue_clause_idx (o_issue_clause_idx),
    .i_core_done        (i_core_done),
    .i_core_conflict    (i_core_conflict)
  );

  always #5 i_clock = ~i_clock;

  int checks   = 0;
  int failures = 0;
  int t        = 0;  // cycle number, advanced at each falling edge
  int m_ptr    = 0;  // next core to favour in round-robin order
  int g_conf   = 0;  // conflict result expected to be held between passes

  typedef struct {
    string name;
    int    sc;
    int    ec;
    int    lat;        // core latency after issue
    int    ccore;      // core whose first clause conflicts, -1 for none
    int    poke;       // drive stray starts while busy and in the done cycle
    int    exp_issues;
    int    exp_lat;    // cycles from start to done
    int    exp_conf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, t);
    end
  endtask

  task automatic check_idle();
    chk("idle_busy", int'(o_busy), 0);
    chk("idle_done", int'(o_done), 0);
    chk("idle_reset_bcp", int'(o_reset_bcp), 0);
    chk("idle_issue_valid", int'(o_issue_valid), 0);
    chk("idle_conflict_held", int'(o_conflict), g_conf);
  endtask

  task automatic idle_cycle();
    @(negedge i_clock);
    t++;
    check_idle();
    i_start         = 1'b0;
    i_core_done     = '0;
    i_core_conflict = '0;
  endtask

  // Runs one complete pass: the model tracks which cores are busy, when each
  // frees up, the next clause to hand out, and when done must appear.
  task automatic run_pass(input int sc, input int ec, input int fixlat, input int ccore,
                          input int cprob, input bit poke,
                          output int n_iss, output int dlat, output int conf_o);
    int s, nxt, endv, k, lastdone, dd, g, c, outst;
    bit dn, found, exp_conf, exp_done, cf;
    int busy_c[NC];
    int free_at[NC];
    int due[NC];
    bit first_c[NC];
    logic [NC-1:0] dbits, cbits;

    nxt = sc;
    endv = (sc > ec) ? sc : ec;
    k = -1; lastdone = -10; dd = -1;
    n_iss = 0; dlat = -1; conf_o = -1;
    dn = 1'b0; exp_conf = 1'b0;
    for (int i = 0; i < NC; i++) begin
      busy_c[i] = 0; free_at[i] = 0; due[i] = 0; first_c[i] = 1'b1;
    end

    @(negedge i_clock);
    t++;
    check_idle();
    s = t;
    i_start         = 1'b1;
    i_start_clause  = CB'(sc);
    i_end_clause    = CB'(ec);
    i_core_done     = '0;
    i_core_conflict = '0;

    while (!dn && (t - s) < 300) begin
      @(negedge i_clock);
      t++;
      if (t == s + 1) begin
        chk("start_reset_bcp", int'(o_reset_bcp), 1);
        chk("start_busy", int'(o_busy), 1);
        chk("start_issue_valid", int'(o_issue_valid), 0);
        chk("start_done", int'(o_done), 0);
        chk("start_conflict_cleared", int'(o_conflict), 0);
      end else begin
        if (dd < 0 && !(((k < 0) || (t <= k + 1)) && (nxt != endv))) dd = t;
        found = 1'b0;
        g = 0;
        if (dd < 0) begin
          for (int i = 0; i < NC; i++) begin
            c = (m_ptr + i) % NC;
            if (!found && busy_c[c] == 0 && t >= free_at[c]) begin
              found = 1'b1;
              g = c;
            end
          end
        end
        if (found) begin
          chk("issue_valid", int'(o_issue_valid), 1 << g);
          chk("issue_idx", int'(o_issue_clause_idx), nxt);
          busy_c[g] = 1;
          due[g] = t + ((fixlat > 0) ? fixlat : int'($urandom_range(1, 5)));
          nxt++;
          m_ptr = (g + 1) % NC;
          n_iss++;
        end else begin
          chk("no_issue", int'(o_issue_valid), 0);
        end
        outst = 0;
        for (int i = 0; i < NC; i++) outst += busy_c[i];
        exp_done = (dd >= 0) && (t >= dd + 1) && (outst == 0) && (lastdone != t - 1);
        chk("done", int'(o_done), int'(exp_done));
        chk("busy", int'(o_busy), int'(!exp_done));
        chk("reset_bcp_low", int'(o_reset_bcp), 0);
        chk("conflict", int'(o_conflict), exp_done ? int'(exp_conf) : 0);
        if (exp_done) begin
          dn = 1'b1;
          dlat = t - s;
          conf_o = int'(o_conflict);
          g_conf = int'(exp_conf);
        end
      end

      dbits = '0;
      cbits = (cprob > 0) ? NC'($urandom) : '0;
      for (int i = 0; i < NC; i++) begin
        if (busy_c[i] != 0 && due[i] == t) begin
          cf = (i == ccore && first_c[i]) ||
               ((cprob > 0) && ($urandom_range(0, cprob - 1) == 0));
          first_c[i] = 1'b0;
          dbits[i] = 1'b1;
          cbits[i] = cf;
          busy_c[i] = 0;
          free_at[i] = t + 2;
          lastdone = t;
          if (cf) begin
            exp_conf = 1'b1;
            if (k < 0) k = t;
          end
        end
      end
      i_core_done     = dbits;
      i_core_conflict = cbits;
      i_start = poke && ((t == s + 3) || dn);
      if (i_start) begin
        i_start_clause = CB'($urandom);
        i_end_clause   = CB'($urandom);
      end
    end
    if (!dn) begin
      checks++;
      failures++;
      $display("FAIL pass_timeout: no done within 300 cycles of start at cycle %0d", s);
    end
  endtask

  initial begin
    int n_iss, dlat, conf_o, s6, sc, ec, sel;

    vecs[0] = '{"rr_basic",     10, 14, 2, -1, 0, 4,  9, 0};
    vecs[1] = '{"empty",         5,  5, 2, -1, 0, 0,  3, 0};
    vecs[2] = '{"conflict",      0, 20, 2,  2, 0, 6, 11, 1};
    vecs[3] = '{"stall_resume",  0,  8, 6, -1, 0, 8, 21, 0};
    vecs[4] = '{"start_ignored", 3,  6, 1, -1, 1, 3,  7, 0};
    vecs[5] = '{"top_of_range", 250, 255, 1, -1, 0, 5,  9, 0};
    vecs[6] = '{"reversed",      9,  4, 1, -1, 0, 0,  3, 0};

    i_reset         = 1'b1;
    i_start         = 1'b0;
    i_start_clause  = '0;
    i_end_clause    = '0;
    i_core_done     = '0;
    i_core_conflict = '0;
    repeat (2) @(negedge i_clock);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_conflict", int'(o_conflict), 0);
    chk("rst_reset_bcp", int'(o_reset_bcp), 0);
    chk("rst_issue_valid", int'(o_issue_valid), 0);
    chk("rst_issue_idx", int'(o_issue_clause_idx), 0);
    i_reset = 1'b0;
    idle_cycle();

    for (int v = 0; v < 7; v++) begin
      run_pass(vecs[v].sc, vecs[v].ec, vecs[v].lat, vecs[v].ccore, 0, vecs[v].poke[0],
               n_iss, dlat, conf_o);
      chk({vecs[v].name, "_issues"}, n_iss, vecs[v].exp_issues);
      chk({vecs[v].name, "_done_latency"}, dlat, vecs[v].exp_lat);
      chk({vecs[v].name, "_conflict"}, conf_o, vecs[v].exp_conf);
      idle_cycle();
      idle_cycle();
    end

    // Reset while clauses are outstanding aborts the pass without a done pulse.
    @(negedge i_clock);
    t++;
    check_idle();
    s6 = t;
    i_start = 1'b1;
    i_start_clause = 8'd0;
    i_end_clause = 8'd20;
    @(negedge i_clock);
    t++;
    i_start = 1'b0;
    chk("abort_busy", int'(o_busy), 1);
    @(negedge i_clock);
    t++;
    chk("abort_issue_valid", int'(o_issue_valid), 1 << m_ptr);
    chk("abort_issue_idx", int'(o_issue_clause_idx), 0);
    i_reset = 1'b1;
    @(negedge i_clock);
    t++;
    i_reset = 1'b0;
    chk("abort_busy_cleared", int'(o_busy), 0);
    chk("abort_done_none", int'(o_done), 0);
    chk("abort_conflict", int'(o_conflict), 0);
    chk("abort_reset_bcp", int'(o_reset_bcp), 0);
    chk("abort_issue_cleared", int'(o_issue_valid), 0);
    chk("abort_idx_cleared", int'(o_issue_clause_idx), 0);
    chk("abort_cycle", t - s6, 3);
    m_ptr = 0;
    g_conf = 0;
    idle_cycle();
    run_pass(100, 103, 2, -1, 0, 1'b0, n_iss, dlat, conf_o);
    chk("after_abort_issues", n_iss, 3);
    chk("after_abort_done_latency", dlat, 8);
    idle_cycle();

    for (int r = 0; r < 40; r++) begin
      sc = int'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 7));
      if (sel == 0) ec = sc;
      else if (sel == 1) ec = int'($urandom_range(0, 255));
      else begin
        ec = sc + int'($urandom_range(1, 24));
        if (ec > 255) ec = 255;
      end
      run_pass(sc, ec, 0, -1, 12, ($urandom_range(0, 3) == 0), n_iss, dlat, conf_o);
      chk("rand_issue_count", n_iss, ((sc > ec) ? 0 : (ec - sc)) < 0 ? 0 :
          (conf_o == 1 ? n_iss : ((sc > ec) ? 0 : (ec - sc))));
      repeat ($urandom_range(1, 3)) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
